// File: rtl/vga_sync_rx_if.sv
// Signal bundle between the VGA timing link and the sync receiver.
// master drives the raw link, slave is the receiver.
interface vga_sync_rx_if #(
    parameter int HW = 12,
    parameter int VW = 11
);
    // pix_valid_o qualifies x_o/y_o/RGB on every clock; no ready exists, the stream never stalls.
    logic          hsync_i;
    logic          vsync_i;
    logic          red_i;
    logic          green_i;
    logic          blue_i;
    logic          locked_o;
    logic [HW-1:0] h_total_o;
    logic [HW-1:0] h_sync_o;
    logic [VW-1:0] v_total_o;
    logic [HW-1:0] x_o;
    logic [VW-1:0] y_o;
    logic          pix_valid_o;
    logic          red_o;
    logic          green_o;
    logic          blue_o;
    logic          dbg_state;

    modport master (
        output hsync_i, vsync_i, red_i, green_i, blue_i,
        input  locked_o, h_total_o, h_sync_o, v_total_o, x_o, y_o,
        input  pix_valid_o, red_o, green_o, blue_o, dbg_state
    );

    modport slave (
        input  hsync_i, vsync_i, red_i, green_i, blue_i,
        output locked_o, h_total_o, h_sync_o, v_total_o, x_o, y_o,
        output pix_valid_o, red_o, green_o, blue_o, dbg_state
    );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: synchronises hsync/vsync/RGB, measures line and frame
// timing, locks on stable timing and emits x/y coordinates with aligned RGB.
module vga_sync_rx #(
    parameter int HW          = 12,
    parameter int VW          = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    vga_sync_rx_if.slave bus
);
    localparam int            MW     = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_FRAMES);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [1:0]    hs_sync, vs_sync, r_sync, g_sync, b_sync;
    logic          hs_prev, vs_prev;
    logic          hs_s, vs_s;
    logic          hs_start, hs_end, vs_start, frame_start;

    logic [HW-1:0] x_q, h_total_q, h_sync_q, hw_cnt_q;
    logic [VW-1:0] y_q, v_total_q, v_total_d;
    logic [HW-1:0] x_inc;
    logic [VW-1:0] y_inc;
    logic          x_sat, y_sat, line_len_ok, frame_len_ok;
    logic [2:0]    rgb_q;
    logic          vs_pend_q, line_ok_q, exempt_q;
    logic          armed_q, armed_d, measured_q, measured_d;
    logic [MW-1:0] match_q, match_d, match_inc;
    logic          locked;

    // Idle level of the active-low syncs is 1, so their synchronisers reset high
    // to avoid a false edge right after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_sync <= 2'b11;
            vs_sync <= 2'b11;
            r_sync  <= 2'b00;
            g_sync  <= 2'b00;
            b_sync  <= 2'b00;
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            hs_sync <= {hs_sync[0], bus.hsync_i};
            vs_sync <= {vs_sync[0], bus.vsync_i};
            r_sync  <= {r_sync[0], bus.red_i};
            g_sync  <= {g_sync[0], bus.green_i};
            b_sync  <= {b_sync[0], bus.blue_i};
            hs_prev <= hs_sync[1];
            vs_prev <= vs_sync[1];
        end
    end

    assign hs_s         = hs_sync[1];
    assign vs_s         = vs_sync[1];
    assign hs_start     = hs_prev & ~hs_s;
    assign hs_end       = ~hs_prev & hs_s;
    assign vs_start     = vs_prev & ~vs_s;
    assign frame_start  = hs_start & (vs_pend_q | vs_start);

    assign x_inc        = x_q + HW'(1);
    assign y_inc        = y_q + VW'(1);
    assign x_sat        = (x_q == {HW{1'b1}});
    assign y_sat        = (y_q == {VW{1'b1}});
    assign line_len_ok  = (x_inc == h_total_q);
    assign frame_len_ok = (y_inc == v_total_q);
    assign match_inc    = match_q + MW'(1);

    // Counters and per-line measurements.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q       <= '0;
            y_q       <= '0;
            h_total_q <= '0;
            h_sync_q  <= '0;
            hw_cnt_q  <= '0;
            rgb_q     <= '0;
            vs_pend_q <= 1'b0;
            line_ok_q <= 1'b0;
            exempt_q  <= 1'b0;
        end else begin
            rgb_q <= {r_sync[1], g_sync[1], b_sync[1]};

            if (hs_start) begin
                x_q       <= '0;
                h_total_q <= x_inc;
            end else if (!x_sat) begin
                x_q <= x_inc;
            end

            if (!hs_s) begin
                if (hw_cnt_q != {HW{1'b1}}) hw_cnt_q <= hw_cnt_q + HW'(1);
            end else begin
                hw_cnt_q <= '0;
            end
            if (hs_end) h_sync_q <= hw_cnt_q;

            if (frame_start)   vs_pend_q <= 1'b0;
            else if (vs_start) vs_pend_q <= 1'b1;

            if (frame_start)                y_q <= '0;
            else if (hs_start && !y_sat)    y_q <= y_inc;

            // The line right after a frame start is exempt: h_total may still
            // hold a stale value after a sync outage.
            if (frame_start) begin
                line_ok_q <= 1'b1;
                exempt_q  <= 1'b1;
            end else if (hs_start) begin
                if (!exempt_q && !line_len_ok) line_ok_q <= 1'b0;
                exempt_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SEARCH;
            armed_q    <= 1'b0;
            measured_q <= 1'b0;
            match_q    <= '0;
            v_total_q  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            measured_q <= measured_d;
            match_q    <= match_d;
            v_total_q  <= v_total_d;
        end
    end

    // First frame start only arms (the frame may be partial), the second
    // takes the reference length, later ones count matching frames.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        measured_d = measured_q;
        match_d    = match_q;
        v_total_d  = v_total_q;
        case (state_q)
            SEARCH: begin
                if (frame_start) begin
                    if (!armed_q) begin
                        armed_d = 1'b1;
                    end else if (!measured_q) begin
                        measured_d = 1'b1;
                        v_total_d  = y_inc;
                        match_d    = '0;
                    end else if (line_ok_q && frame_len_ok) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_M) state_d = LOCKED;
                    end else begin
                        match_d   = '0;
                        v_total_d = y_inc;
                    end
                end else if (x_sat && !hs_start) begin
                    armed_d    = 1'b0;
                    measured_d = 1'b0;
                    match_d    = '0;
                end
            end
            LOCKED: begin
                if ((hs_start && !line_len_ok) || (frame_start && !frame_len_ok) ||
                    x_sat || y_sat) begin
                    state_d    = SEARCH;
                    armed_d    = 1'b0;
                    measured_d = 1'b0;
                    match_d    = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign locked          = (state_q == LOCKED);
    assign bus.locked_o    = locked;
    assign bus.pix_valid_o = locked;
    assign bus.dbg_state   = state_q;
    assign bus.h_total_o   = h_total_q;
    assign bus.h_sync_o    = h_sync_q;
    assign bus.v_total_o   = v_total_q;
    assign bus.x_o         = x_q;
    assign bus.y_o         = y_q;
    assign bus.red_o       = rgb_q[2];
    assign bus.green_o     = rgb_q[1];
    assign bus.blue_o      = rgb_q[0];
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the board's 640x480-class VGA timing link. Samples active-low hsync/vsync and 1-bit RGB and measures line period, hsync width and lines per frame.
- Locks once the timing is stable and emits per-pixel x/y coordinates with aligned RGB.
- Used for loopback self-test of the VGA generator and as the front end of a future capture path.

Parameters:
- HW, 12, width of horizontal counters and measurements (clocks).
- VW, 11, width of vertical counters and measurements (lines).
- LOCK_FRAMES, 2, consecutive matching frames required to lock.

Ports:
- clk_i  in  1  pixel clock, 25 MHz nominal.
- rst_i  in  1  reset. Asynchronous, active-high.
- hsync_i  in  1  horizontal sync, active-low, asynchronous to clk_i.
- vsync_i  in  1  vertical sync, active-low, asynchronous to clk_i.
- red_i, green_i, blue_i  in  1 each  pixel colour.
- locked_o  out  1  timing locked.
- h_total_o  out  HW  last measured line period in clocks.
- h_sync_o  out  HW  last measured hsync low width in clocks.
- v_total_o  out  VW  last measured frame length in lines.
- x_o  out  HW  clocks since hsync assertion.
- y_o  out  VW  lines since frame start.
- pix_valid_o  out  1  equals locked_o, aligned with x_o/y_o.
- red_o, green_o, blue_o  out  1 each  registered RGB, aligned with x_o/y_o.

Behaviour:
- Reset: all outputs 0. All counters 0. FSM in SEARCH. Armed flag 0.
- Input sync: a 2-flop synchronizer on all five inputs, followed by one history flop each for hsync and vsync.
- hs_start: synced hsync goes 1->0. vs_start: synced vsync goes 1->0.
- Horizontal counter:
  - On hs_start: x_o<=0; h_total_o<=x_o+1.
  - Otherwise x_o<=x_o+1, saturating at 2^HW-1.
- Hsync width:
  - A width counter runs while synced hsync is 0.
  - On the 0->1 edge: h_sync_o<=count.
- RGB: red_o/green_o/blue_o<=synced RGB every cycle, so they carry the pixel at x_o.
- Frame start:
  - vs_start sets vs_pend.
  - Frame start is the first hs_start with vs_pend set, or with vs_start in the same cycle. vs_pend then clears.
  - On hs_start that is not a frame start: y_o<=y_o+1, saturating at 2^VW-1.
  - On frame start: y_o<=0.
- Line stability:
  - line_ok clears if any hs_start within the frame has x_o+1 != h_total_o.
  - The first hs_start after a frame start is exempt.
  - line_ok is set again at each frame start.
- FSM SEARCH:
  - 1st frame start: armed<=1. Nothing is latched.
  - 2nd frame start: v_total_o<=y_o+1, match_cnt<=0.
  - Later frame starts: if line_ok and y_o+1==v_total_o, match_cnt++; else match_cnt<=0 and v_total_o<=y_o+1.
  - match_cnt==LOCK_FRAMES -> LOCKED. locked_o rises the cycle after that frame start.
- FSM LOCKED. Drop to SEARCH on any of:
  - hs_start with x_o+1 != h_total_o;
  - frame start with y_o+1 != v_total_o;
  - x_o or y_o saturation.
- On leaving LOCKED: locked_o<=0, armed<=0, match_cnt<=0. The measurement outputs hold their values.
- Timeout: saturated x_o means no sync is present. In SEARCH this clears armed.
- Simultaneous hs_start and vs_start is a frame start (the generator asserts both on the same clock).
- Reset mid-frame: the partial frame is discarded via the arming step. Lock requires full frames only.

Test Plan:
- Loopback from the generator (768 clk/line, 16 clk hsync, 512 lines/frame), rx reset released mid-frame:
  - h_total_o=768, h_sync_o=16, v_total_o=512;
  - locked_o rises the cycle after the 4th frame start;
  - x_o wraps 767->0, y_o wraps 511->0.
- Once locked, the generator pattern column marker is present: red_o=green_o=blue_o=1 at exactly one x_o per line, a fixed offset from x=256 set by the pipeline delay. The bench checks that this x_o is constant on every line.
- Stretch one line to 769 clocks while locked:
  - locked_o falls the cycle after that hs_start;
  - relock after 4 further clean frame starts.
- Hold hsync_i high after lock: x_o saturates at 4095 and locked_o falls. Resuming sync relocks after 4 frame starts.
- Frames alternating 512/513 lines: locked_o never asserts, and v_total_o tracks the last frame.
- Assert rst_i asynchronously while locked: all outputs read 0 immediately, with no clock edge needed. After release, lock is reacquired at the 4th frame start.
